// File: rtl/ee201_timing_pkg.sv
// Shared timing definitions for the ee201 game-timing blocks.
package ee201_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int unsigned DIV_60HZ       = 1666667;
  localparam int unsigned DIV_1KHZ       = 100000;
  localparam int unsigned CWIDTH_DEFAULT = 8;

endpackage

// File: rtl/ee201_tick_prescaler.sv
// Free-running prescaler: one registered Tick pulse every PRESCALE enabled clocks.
module ee201_tick_prescaler
  import ee201_timing_pkg::*;
#(
  parameter int unsigned PRESCALE = DIV_60HZ,
  parameter int unsigned PWIDTH   = 21
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  localparam logic [PWIDTH-1:0] PMAX = PWIDTH'(PRESCALE - 1);

  logic [PWIDTH-1:0] pcount;

  // count is frozen while disabled, and no tick escapes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pcount <= '0;
      Tick   <= 1'b0;
    end else if (Enable) begin
      if (pcount == PMAX) begin
        pcount <= '0;
        Tick   <= 1'b1;
      end else begin
        pcount <= pcount + PWIDTH'(1);
        Tick   <= 1'b0;
      end
    end else begin
      Tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ee201_tick_scheduler.sv
// Shared delay timer: round-robin grants one requester at a time a delay of
// Count ticks and pulses Done to the owner when it expires.
module ee201_tick_scheduler
  import ee201_timing_pkg::*;
#(
  parameter int unsigned PRESCALE = DIV_60HZ,
  parameter int unsigned PWIDTH   = 21,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CWIDTH   = CWIDTH_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Cancel,
  input  logic [NCH-1:0]        Req,
  input  logic [NCH*CWIDTH-1:0] Count,
  output logic [NCH-1:0]        Ack,
  output logic [NCH-1:0]        Done,
  output logic                  Busy,
  output logic [2:0]            Owner,
  output logic                  Tick
);

  localparam int unsigned OW = 3;

  sched_state_t      state, state_n;
  logic [CWIDTH-1:0] rem, rem_n, gcnt;
  logic [OW-1:0]     last, last_n, owner_n, gsel;
  logic [NCH-1:0]    ack_n, done_n;
  logic              gvalid;
  int unsigned       rr_idx;

  ee201_tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PWIDTH   (PWIDTH)
  ) u_prescaler (
    .Clk    (Clk),
    .Reset  (Reset),
    .Enable (Enable),
    .Tick   (Tick)
  );

  // round-robin search starting one past the last granted channel
  always_comb begin
    gvalid = 1'b0;
    gsel   = '0;
    gcnt   = '0;
    rr_idx = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      rr_idx = (32'(last) + k) % NCH;
      if (!gvalid && |(Req & (NCH'(1) << rr_idx))) begin
        gvalid = 1'b1;
        gsel   = OW'(rr_idx);
        gcnt   = CWIDTH'(Count >> (rr_idx * CWIDTH));
      end
    end
  end

  // next state and next values of the registered outputs
  always_comb begin
    state_n = state;
    rem_n   = rem;
    last_n  = last;
    owner_n = Owner;
    ack_n   = '0;
    done_n  = '0;
    unique case (state)
      ST_IDLE: begin
        if (gvalid) begin
          owner_n = gsel;
          last_n  = gsel;
          rem_n   = gcnt;
          ack_n   = NCH'(1) << gsel;
          state_n = (gcnt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (Cancel) begin
          state_n = ST_IDLE;
          rem_n   = '0;
        end else if (Tick) begin
          rem_n = rem - CWIDTH'(1);
          if (rem == CWIDTH'(1)) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        rem_n   = '0;
        if (!Cancel) done_n = NCH'(1) << Owner;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      last  <= OW'(NCH - 1);
      Owner <= '0;
      Ack   <= '0;
      Done  <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      last  <= last_n;
      Owner <= owner_n;
      Ack   <= ack_n;
      Done  <= done_n;
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule
